multicycle_addsub: RTL and testbench

Parametrised signed/unsigned adder-subtractor. Operands are WIDTH bits and are processed in CHUNK-bit slices, one slice per clock, with a ripple carry held in a register between slices. The block adds a valid/ready handshake on both input and output, optional signed saturation, and carry/zero flags. It sits in the datapath as a low-area arithmetic unit for wide operands.

---
 rtl/multicycle_addsub.sv | 137 +++++++++++++
 tb/tb_multicycle_addsub.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_addsub.sv
// Adder-subtractor that processes CHUNK bits per clock with a registered ripple carry; result is valid NCHUNK edges after accept.
// Single operation in flight: in_ready only in IDLE, and the result is held in DONE until out_ready.
module multicycle_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             cout,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovfl_q, ovfl_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice_sum;
  logic             msb_cin;
  logic             ovf_w;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sat_d   = sat_q;
    res_d   = res_q;
    ovfl_d  = ovfl_q;
    cout_d  = cout_q;
    zero_d  = zero_q;

    // Operands shift right each RUN cycle, so the active slice is always the low CHUNK bits.
    a_sl      = opa_q[CHUNK-1:0];
    b_sl      = opb_q[CHUNK-1:0];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from its sum bit; valid for CHUNK=1 as well.
    msb_cin   = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1];
    ovf_w     = msb_cin ^ slice_sum[CHUNK];
    sat_val   = a_sl[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    res_w = res_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) res_w[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          sat_d   = sat;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_w;
        carry_d = slice_sum[CHUNK];
        opa_d   = opa_q >> CHUNK;
        opb_d   = opb_q >> CHUNK;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          state_d = DONE;
          cout_d  = slice_sum[CHUNK];
          ovfl_d  = ovf_w;
          if (sat_q && ovf_w) res_d = sat_val;
          zero_d  = (res_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      ovfl_q  <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sat_q   <= sat_d;
      res_q   <= res_d;
      ovfl_q  <= ovfl_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign ovfl      = ovfl_q;
  assign cout      = cout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: CHUNK=8 and CHUNK=32 instances share stimulus; results checked from a scoreboard queue.
module tb_multicycle_addsub;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic [31:0] res;
    logic        ovfl;
    logic        cout;
    logic        zero;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        sub, sat;
  logic        out_ready;

  logic        ir8, ov8, ovf8, co8, z8;
  logic [31:0] res8;
  logic        ir32, ov32, ovf32, co32, z32;
  logic [31:0] res32;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  bit  pv8   = 0;
  bit  pv32  = 0;
  sb_t q8[$];
  sb_t q32[$];
  vec_t tbl[14];

  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .ovfl(ovf8), .cout(co8), .zero(z8)
  );

  multicycle_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
    .a(a), .b(b), .sub(sub), .sat(sat),
    .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .ovfl(ovf32), .cout(co32), .zero(z32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic msub, input logic msat);
    vec_t        v;
    logic [32:0] f;
    logic [31:0] r;
    logic        ov;
    f  = {1'b0, ma} + {1'b0, (msub ? ~mb : mb)} + {32'd0, msub};
    r  = f[31:0];
    ov = msub ? ((ma[31] != mb[31]) && (r[31] != ma[31]))
              : ((ma[31] == mb[31]) && (r[31] != ma[31]));
    v.a = ma; v.b = mb; v.sub = msub; v.sat = msat;
    v.cout = f[32];
    v.ovfl = ov;
    if (msat && ov) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    v.res  = r;
    v.zero = (r == 32'd0);
    return v;
  endfunction

  task automatic mon(input int sel, input logic vld, input logic pv, input logic [31:0] res,
                     input logic f_ov, input logic f_co, input logic f_z);
    sb_t e;
    int  qs;
    int  lat;
    qs  = (sel == 8) ? q8.size() : q32.size();
    lat = (sel == 8) ? 4 : 1;
    if (vld && !pv) begin
      if (qs == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_valid_%0d: out_valid=1 with nothing outstanding, required 0", sel);
      end else begin
        e = (sel == 8) ? q8[0] : q32[0];
        chk($sformatf("latency_%0d", sel), cyc - e.acc, lat);
      end
    end
    if (vld && out_ready && qs != 0) begin
      e = (sel == 8) ? q8.pop_front() : q32.pop_front();
      chk($sformatf("result_%0d a=%h b=%h", sel, e.v.a, e.v.b), res, e.v.res);
      chk($sformatf("ovfl_%0d a=%h b=%h", sel, e.v.a, e.v.b), {31'd0, f_ov}, {31'd0, e.v.ovfl});
      chk($sformatf("cout_%0d a=%h b=%h", sel, e.v.a, e.v.b), {31'd0, f_co}, {31'd0, e.v.cout});
      chk($sformatf("zero_%0d a=%h b=%h", sel, e.v.a, e.v.b), {31'd0, f_z}, {31'd0, e.v.zero});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv8  = 1'b0;
      pv32 = 1'b0;
    end else begin
      mon(8, ov8, pv8, res8, ovf8, co8, z8);
      mon(32, ov32, pv32, res32, ovf32, co32, z32);
      pv8  = ov8;
      pv32 = ov32;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input vec_t v, input bit p8, input bit p32);
    sb_t e;
    int  t = 0;
    while (!(ir8 && ir32) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) chk("in_ready_timeout", {31'd0, ir8 && ir32}, 32'd1);
    a = v.a; b = v.b; sub = v.sub; sat = v.sat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.v = v; e.acc = cyc;
    if (p8)  q8.push_back(e);
    if (p32) q32.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() != 0 || q32.size() != 0) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk("drain_timeout", q8.size() + q32.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1, v2;
    //            a              b              sub   sat   res            ovfl  cout  zero
    tbl[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{32'h00FF_00FF, 32'h0000_FF00, 1'b1, 1'b0, 32'h00FE_01FF, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_8", {31'd0, ir8}, 32'd1);
    chk("rst_out_valid_8", {31'd0, ov8}, 32'd0);
    chk("rst_result_8", res8, 32'd0);
    chk("rst_flags_8", {29'd0, ovf8, co8, z8}, 32'd0);
    chk("rst_in_ready_32", {31'd0, ir32}, 32'd1);
    chk("rst_out_valid_32", {31'd0, ov32}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i], 1'b1, 1'b1);
      drain();
    end

    // Random ops issued back to back; each waits only for both units to be idle.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 6 == 1) rb = 32'h8000_0000;
      if (i % 6 == 2) rb = ra;
      issue(model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), 1'b1, 1'b1);
    end
    drain();

    // Backpressure: result held, new op ignored until after the handshake.
    v1 = tbl[0];
    v2 = tbl[11];
    out_ready = 1'b0;
    issue(v1, 1'b1, 1'b1);
    begin
      int t = 0;
      while (!ov8 && t < 20) begin
        @(posedge clk); #1; t++;
      end
      chk("bp_out_valid_rise", {31'd0, ov8}, 32'd1);
    end
    a = v2.a; b = v2.b; sub = v2.sub; sat = v2.sat; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_result_8_c%0d", k), res8, v1.res);
      chk($sformatf("bp_flags_8_c%0d", k), {29'd0, ovf8, co8, z8}, {29'd0, v1.ovfl, v1.cout, v1.zero});
      chk($sformatf("bp_in_ready_8_c%0d", k), {31'd0, ir8}, 32'd0);
      chk($sformatf("bp_out_valid_8_c%0d", k), {31'd0, ov8}, 32'd1);
      chk($sformatf("bp_result_32_c%0d", k), res32, v1.res);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after_8", {31'd0, ir8}, 32'd1);
    chk("bp_in_ready_after_32", {31'd0, ir32}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      sb_t e;
      e.v = v2; e.acc = cyc;
      q8.push_back(e);
      q32.push_back(e);
    end
    drain();

    // Reset two edges after accept aborts the CHUNK=8 op; the CHUNK=32 op has already completed.
    issue(tbl[0], 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid_8", {31'd0, ov8}, 32'd0);
    chk("abort_in_ready_8", {31'd0, ir8}, 32'd1);
    chk("abort_result_8", res8, 32'd0);
    chk("abort_flags_8", {29'd0, ovf8, co8, z8}, 32'd0);
    chk("abort_in_ready_32", {31'd0, ir32}, 32'd1);
    chk("abort_result_32", res32, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_quiet_8_c%0d", k), {31'd0, ov8}, 32'd0);
    end
    q32.delete();

    issue(tbl[0], 1'b1, 1'b1);
    drain();
    issue(tbl[2], 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
